// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared widths, BCD word type and digit helpers for the FND scan controller
package fnd_pkg;
    localparam int FND_NUM_DIGITS = 4;
    localparam int FND_SEL_W      = 2;
    localparam int FND_BCD_W      = 4;
    localparam int FND_WORD_W     = 16;

    typedef logic [FND_WORD_W-1:0] fnd_word_t;
    typedef logic [FND_SEL_W-1:0]  fnd_sel_t;
    typedef logic [FND_BCD_W-1:0]  fnd_bcd_t;

    function automatic fnd_bcd_t fnd_digit(input fnd_word_t word, input fnd_sel_t sel);
        return word[sel*FND_BCD_W +: FND_BCD_W];
    endfunction

    // True when sel is above digit 0 and it and every digit above it are zero.
    function automatic logic fnd_lz_blank(input fnd_word_t word, input fnd_sel_t sel);
        logic zero_above;
        zero_above = 1'b1;
        for (int i = FND_NUM_DIGITS-1; i > 0; i--) begin
            if (i >= int'(sel)) begin
                zero_above = zero_above && (word[i*FND_BCD_W +: FND_BCD_W] == '0);
            end
        end
        return (sel != '0) && zero_above;
    endfunction
endpackage

// File: rtl/fnd_scan_controller_if.sv
// rtl/fnd_scan_controller_if.sv - display word load/enable inputs and scan outputs of the FND scan controller
interface fnd_scan_controller_if;
    import fnd_pkg::*;

    fnd_word_t i_bcd;
    logic      i_load;
    logic      i_en;
    fnd_sel_t  o_digitSelect;
    fnd_bcd_t  o_value;
    logic      o_en;
    logic      o_pending;
    logic      o_frameDone;

    modport master (
        output i_bcd, i_load, i_en,
        input  o_digitSelect, o_value, o_en, o_pending, o_frameDone
    );

    modport slave (
        input  i_bcd, i_load, i_en,
        output o_digitSelect, o_value, o_en, o_pending, o_frameDone
    );
endinterface

// File: rtl/fnd_scan_tick.sv
// rtl/fnd_scan_tick.sv - free-running digit slot counter 0..SCAN_DIV-1 with a wrap tick on the last cycle
module fnd_scan_tick #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);
    assign wrap = (cnt == CNT_W'(SCAN_DIV-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - 4-digit BCD scan controller with frame-aligned double buffering and blank time
// Optional leading-zero blanking: define FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    fnd_scan_controller_if.slave  bus
);
    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             wrap;
    logic             frame_boundary;
    logic             blank_next;
    fnd_sel_t         digit;
    fnd_sel_t         digit_next;
    fnd_word_t        pending;
    fnd_word_t        active;
    fnd_word_t        active_next;
    logic             pending_valid;

    fnd_scan_tick #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    // Outputs are registered from next-state values so select, value and enable line up with the slot.
    always_comb begin
        cnt_next       = wrap ? '0 : cnt + CNT_W'(1);
        digit_next     = wrap ? digit + FND_SEL_W'(1) : digit;
        frame_boundary = wrap && (digit == FND_SEL_W'(FND_NUM_DIGITS-1));
        active_next    = active;
        if (frame_boundary && bus.i_load) begin
            active_next = bus.i_bcd;
        end else if (frame_boundary && pending_valid) begin
            active_next = pending;
        end
    end

`ifdef FND_LEADING_ZERO_BLANK_EN
    assign blank_next = fnd_lz_blank(active_next, digit_next);
`else
    assign blank_next = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            digit           <= '0;
            pending         <= '0;
            active          <= '0;
            pending_valid   <= 1'b0;
            bus.o_value     <= '0;
            bus.o_en        <= 1'b0;
            bus.o_frameDone <= 1'b0;
        end else begin
            digit  <= digit_next;
            active <= active_next;
            if (bus.i_load) begin
                pending       <= bus.i_bcd;
                pending_valid <= !frame_boundary;
            end else if (frame_boundary) begin
                pending_valid <= 1'b0;
            end
            bus.o_value     <= fnd_digit(active_next, digit_next);
            bus.o_en        <= bus.i_en && (cnt_next >= CNT_W'(BLANK_CYCLES)) && !blank_next;
            bus.o_frameDone <= (digit_next == FND_SEL_W'(FND_NUM_DIGITS-1)) &&
                               (cnt_next == CNT_W'(SCAN_DIV-1));
        end
    end

    assign bus.o_digitSelect = digit;
    assign bus.o_pending     = pending_valid;
endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb/tb_fnd_scan_controller.sv - directed self-checking bench for fnd_scan_controller (SCAN_DIV=8, BLANK_CYCLES=2)
module tb_fnd_scan_controller;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

`ifdef FND_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] MASK_0070 = 4'b0011;
    localparam logic [3:0] MASK_0B0F = 4'b0111;
    localparam logic [3:0] MASK_0000 = 4'b0001;
`else
    localparam logic [3:0] MASK_0070 = 4'b1111;
    localparam logic [3:0] MASK_0B0F = 4'b1111;
    localparam logic [3:0] MASK_0000 = 4'b1111;
`endif

    fnd_scan_controller_if bus ();

    fnd_scan_controller #(
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
        cyc += n;
    endtask

    // Walks one full frame from digit 0; i_en is dropped at cycle drop and raised at cycle rise.
    task automatic check_frame(input logic [15:0] word, input logic [3:0] mask,
                               input int drop, input int rise);
        for (int k = 0; k < 32; k++) begin
            int          d;
            int          c;
            logic        exp_en;
            logic [15:0] sh;
            if (cyc == drop) bus.i_en = 1'b0;
            if (cyc == rise) bus.i_en = 1'b1;
            d      = k / 8;
            c      = k % 8;
            sh     = word >> (4 * d);
            exp_en = mask[d] && (c >= 2) && !(cyc > drop && cyc <= rise);
            chk("frame_sel",     16'(bus.o_digitSelect), 16'(d));
            chk("frame_value",   16'(bus.o_value),       {12'h000, sh[3:0]});
            chk("frame_en",      16'(bus.o_en),          exp_en ? 16'd1 : 16'd0);
            chk("frame_done",    16'(bus.o_frameDone),   (k == 31) ? 16'd1 : 16'd0);
            chk("frame_pending", 16'(bus.o_pending),     16'd0);
            tick(1);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        bus.i_bcd  = 16'h0000;
        bus.i_load = 1'b0;
        bus.i_en   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel",     16'(bus.o_digitSelect), 16'd0);
        chk("rst_value",   16'(bus.o_value),       16'd0);
        chk("rst_en",      16'(bus.o_en),          16'd0);
        chk("rst_pending", 16'(bus.o_pending),     16'd0);
        chk("rst_done",    16'(bus.o_frameDone),   16'd0);

        @(negedge clk);
        rst_n      = 1'b1;
        cyc        = 0;
        bus.i_bcd  = 16'h4321;
        bus.i_load = 1'b1;
        bus.i_en   = 1'b1;
        tick(1);
        bus.i_load = 1'b0;
        chk("load_pending", 16'(bus.o_pending), 16'd1);
        chk("old_value",    16'(bus.o_value),   16'd0);
        tick(29);
        chk("done_early",   16'(bus.o_frameDone), 16'd0);
        tick(1);
        chk("done_last",    16'(bus.o_frameDone),   16'd1);
        chk("done_sel",     16'(bus.o_digitSelect), 16'd3);
        tick(1);
        check_frame(16'h4321, 4'b1111, -1, -1);

        tick(11);
        chk("mid_sel", 16'(bus.o_digitSelect), 16'd1);
        bus.i_bcd  = 16'h9999;
        bus.i_load = 1'b1;
        tick(1);
        bus.i_load = 1'b0;
        chk("mid_pending", 16'(bus.o_pending), 16'd1);
        chk("mid_old_d1",  16'(bus.o_value),   16'd2);
        tick(4);
        chk("mid_old_d2",  16'(bus.o_value),   16'd3);
        tick(16);
        check_frame(16'h9999, 4'b1111, -1, -1);

        tick(31);
        chk("coinc_done",    16'(bus.o_frameDone), 16'd1);
        chk("coinc_pending", 16'(bus.o_pending),   16'd0);
        bus.i_bcd  = 16'h5678;
        bus.i_load = 1'b1;
        tick(1);
        bus.i_load = 1'b0;
        check_frame(16'h5678, 4'b1111, -1, -1);

        check_frame(16'h5678, 4'b1111, 194, 214);

        bus.i_bcd  = 16'h0070;
        bus.i_load = 1'b1;
        tick(1);
        bus.i_load = 1'b0;
        chk("lz_pending", 16'(bus.o_pending), 16'd1);
        tick(31);
        check_frame(16'h0070, MASK_0070, -1, -1);

        bus.i_bcd  = 16'h0B0F;
        bus.i_load = 1'b1;
        tick(1);
        bus.i_load = 1'b0;
        tick(31);
        check_frame(16'h0B0F, MASK_0B0F, -1, -1);

        tick(19);
        chk("pre_rst_sel",   16'(bus.o_digitSelect), 16'd2);
        chk("pre_rst_value", 16'(bus.o_value),       16'h000B);
        chk("pre_rst_en",    16'(bus.o_en),          16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_sel",     16'(bus.o_digitSelect), 16'd0);
        chk("async_value",   16'(bus.o_value),       16'd0);
        chk("async_en",      16'(bus.o_en),          16'd0);
        chk("async_pending", 16'(bus.o_pending),     16'd0);
        chk("async_done",    16'(bus.o_frameDone),   16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        check_frame(16'h0000, MASK_0000, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Time-multiplexing scan controller that drives the FND digit/font decoder. It holds a 4-digit packed BCD word, cycles the digit select through digits 0..3 at a programmable refresh rate, and presents the matching BCD nibble and enable each slot. It inserts anti-ghosting blank time at the start of every slot. New display words are double-buffered so a word never changes in the middle of a scan frame.

## Interface
- SCAN_DIV, 100000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 4: cycles at the start of each slot with o_en forced low; must be < SCAN_DIV.

- i_clk  input  1  system clock; all state on rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_bcd  input  16  four BCD digits; [3:0] is digit 0 (least significant), [15:12] is digit 3.
- i_load  input  1  one-cycle strobe that captures i_bcd.
- i_en  input  1  display enable; when low, digits are dark but scanning continues.
- o_digitSelect  output  2  current digit index, 0..3.
- o_value  output  4  BCD nibble for the current digit.
- o_en  output  1  digit enable for the decoder.
- o_pending  output  1  a captured word is waiting for the next frame boundary.
- o_frameDone  output  1  one-cycle pulse in the last cycle of digit 3's slot.

## Operation
- Slot counter cnt runs 0..SCAN_DIV-1 and wraps to 0. A wrap advances the digit: 0→1→2→3→0.
- The frame boundary is the wrap out of digit 3.
- Two 16-bit registers: pending and active.
  - i_load: i_bcd→pending, o_pending set.
  - At a frame boundary with o_pending=1: pending→active, o_pending cleared.
- i_load coincident with a frame boundary: i_bcd goes straight to active and o_pending is cleared. The new word is shown from digit 0 of the new frame.
- Repeated i_load within one frame: the last capture wins.
- o_value = active[4*d+3:4*d], where d is the current digit.
- BCD codes 10..15 pass through unmodified; the decoder handles them.
- o_en = 1 only when all of the following hold:
  - i_en is high (registered one cycle earlier);
  - cnt ≥ BLANK_CYCLES;
  - the digit is not blanked (see Configuration).

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Reset values: o_digitSelect=0, o_value=0, o_en=0, o_pending=0, o_frameDone=0. Also cnt=0, active=0, pending=0.
- Reset asserted mid-slot clears everything immediately (asynchronous). The first slot after release is digit 0 with a full SCAN_DIV length.
- o_digitSelect and o_value change in the same cycle, on the first cycle of the new slot.
- o_en is low for exactly BLANK_CYCLES cycles per slot and high for SCAN_DIV-BLANK_CYCLES cycles (when i_en=1).
- i_en toggling affects o_en one cycle later. It does not affect the counters.
- o_frameDone is high in the cycle where digit=3 and cnt=SCAN_DIV-1.
- A full frame is 4·SCAN_DIV cycles.
- i_load → o_pending: 1-cycle latency.
- Worst-case i_load → visible on digit 0: 4·SCAN_DIV cycles.

## Configuration
- Macro: FND_LEADING_ZERO_BLANK_EN.
- Defined: digits 3..1 that are 0 and have only zero digits above them get o_en=0 for the whole slot. Digit 0 is never blanked, so 0000 shows "0".
- Undefined: every digit is enabled subject only to i_en and blank time.
- Scan timing is identical in both builds.

## Structure
- Shared package fnd_pkg holds:
  - FND_NUM_DIGITS=4, FND_SEL_W=2, FND_BCD_W=4, FND_WORD_W=16;
  - a typedef for the packed BCD word.
- Sub-module fnd_scan_tick: parameterised SCAN_DIV slot counter. It outputs cnt and a wrap tick.
- The top level holds the digit counter, the buffers and the output registers.

## Test plan
Each scenario uses SCAN_DIV=8 and BLANK_CYCLES=2.
- Reset, then i_bcd=0x4321 with i_load and i_en=1 → o_pending high after 1 cycle. From the next frame, o_value reads 1,2,3,4 on digits 0..3. Each slot is 8 cycles with o_en low for the first 2.
- i_load of 0x9999 at cnt=3 of digit 1 → the current frame still shows the old word. The new word appears at digit 0 after the boundary and o_pending clears there.
- i_load asserted in the same cycle as o_frameDone → next digit 0 shows the new word and o_pending stays 0.
- i_en low for 20 cycles mid-frame → o_en is 0 from one cycle after i_en falls until one cycle after i_en rises. o_digitSelect sequencing is unaffected.
- i_bcd=0x0070 with FND_LEADING_ZERO_BLANK_EN defined → digits 3 and 2 have o_en=0, digits 1 and 0 enabled. With the macro undefined, all four digits are enabled.
- Assert i_reset_n low mid-slot of digit 2 → all outputs read 0 immediately. After release, scanning restarts at digit 0 with active=0.
